// File: rtl/inst_buf_pkg.sv
// -----------------------------------------------------------------------------
// inst_buf_pkg
//   Shared definitions for the fetch-to-decode instruction buffer: the packed
//   entry layout (bit offsets of each field within one 104-bit entry) and a
//   helper that builds an entry from its fields.
//
//   Entry layout (MSB..LSB): pc[31:0] | inst[31:0] | pred_addr[31:0] |
//                            is_exc | cause[6:0]
// -----------------------------------------------------------------------------
package inst_buf_pkg;

  localparam int EXC_CAUSE_W = 7;
  localparam int ENTRY_W     = 104;

  localparam int CAUSE_OFF = 0;
  localparam int EXC_OFF   = CAUSE_OFF + EXC_CAUSE_W;  // 7
  localparam int PRED_OFF  = EXC_OFF + 1;              // 8
  localparam int INST_OFF  = PRED_OFF + 32;            // 40
  localparam int PC_OFF    = INST_OFF + 32;            // 72

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t pack_entry(
    input logic [31:0]            pc,
    input logic [31:0]            inst,
    input logic [31:0]            pred,
    input logic                   is_exc,
    input logic [EXC_CAUSE_W-1:0] cause
  );
    entry_t e;
    e                          = '0;
    e[PC_OFF    +: 32]         = pc;
    e[INST_OFF  +: 32]         = inst;
    e[PRED_OFF  +: 32]         = pred;
    e[EXC_OFF]                 = is_exc;
    e[CAUSE_OFF +: EXC_CAUSE_W] = cause;
    return e;
  endfunction

endpackage

// File: rtl/inst_buf_perf.sv
// -----------------------------------------------------------------------------
// inst_buf_perf
//   Saturating performance counters for the instruction buffer. The whole
//   module only exists when INST_BUF_PERF_EN is defined.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     full_evt          fetch presented a pair while the buffer was full
//     flush_evt         flush asserted this cycle
//     perf_full_cycles  cycles with full_evt, saturates at 0xFFFFFFFF
//     perf_flush_cnt    flush cycles, saturates at 0xFFFFFFFF
//   Only rst clears the counters; flush does not.
// -----------------------------------------------------------------------------
`ifdef INST_BUF_PERF_EN
module inst_buf_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        full_evt,
  input  logic        flush_evt,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_flush_cnt
);

  logic [31:0] full_cnt_q,  full_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    full_cnt_d  = full_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (full_evt  && (full_cnt_q  != '1)) full_cnt_d  = full_cnt_q  + 32'd1;
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      full_cnt_q  <= full_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_full_cycles = full_cnt_q;
  assign perf_flush_cnt   = flush_cnt_q;

endmodule
`endif

// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   FIFO between the I-cache fetch stage and decode. Accepts a pair of
//   instructions per cycle (or a single entry when the pair carries a fetch
//   exception), presents the two oldest entries to decode, and lets decode
//   consume 0..2 per cycle. flush empties the buffer.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     flush                    empties the buffer next cycle; wins over push/pop
//     in_valid, in_inst1/2, in_pc1/2, in_pred_addr,
//     in_is_exception, in_exception_cause     fetch pair
//     buf_full                 fewer than two free entries (registered state)
//     out_valid1/2 .. out_exception_cause1/2  head / head+1 entry, zeroed when
//                                             the slot is not valid
//     dec_pop                  entries consumed by decode (clamped to count)
//
//   Build option: define INST_BUF_PERF_EN to add perf_full_cycles and
//   perf_flush_cnt output ports backed by inst_buf_perf.
// -----------------------------------------------------------------------------
module inst_buffer
  import inst_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            in_inst1,
  input  logic [31:0]            in_inst2,
  input  logic [31:0]            in_pc1,
  input  logic [31:0]            in_pc2,
  input  logic [31:0]            in_pred_addr,
  input  logic                   in_is_exception,
  input  logic [EXC_CAUSE_W-1:0] in_exception_cause,
  output logic                   buf_full,
  output logic                   out_valid1,
  output logic                   out_valid2,
  output logic [31:0]            out_inst1,
  output logic [31:0]            out_inst2,
  output logic [31:0]            out_pc1,
  output logic [31:0]            out_pc2,
  output logic [31:0]            out_pred_addr1,
  output logic [31:0]            out_pred_addr2,
  output logic                   out_is_exception1,
  output logic                   out_is_exception2,
  output logic [EXC_CAUSE_W-1:0] out_exception_cause1,
  output logic [EXC_CAUSE_W-1:0] out_exception_cause2,
  input  logic [1:0]             dec_pop
`ifdef INST_BUF_PERF_EN
  ,
  output logic [31:0]            perf_full_cycles,
  output logic [31:0]            perf_flush_cnt
`endif
);

  logic [PTR_W-1:0] head_q,  head_d;
  logic [PTR_W-1:0] tail_q,  tail_d;
  logic [PTR_W:0]   count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  logic [PTR_W:0]   free_slots;
  logic             push_ok;
  logic [1:0]       push_n;
  logic [1:0]       eff_pop;
  entry_t           wr_entry1, wr_entry2;
  entry_t           slot1, slot2;

  assign free_slots = (PTR_W+1)'(DEPTH) - count_q;
  assign buf_full   = free_slots < (PTR_W+1)'(2);
  assign push_ok    = in_valid & ~flush & ~buf_full;
  // An exception pair keeps only its first instruction.
  assign push_n     = in_is_exception ? 2'd1 : 2'd2;
  // dec_pop > count can only happen when count <= 2, so count fits in 2 bits.
  assign eff_pop    = ((PTR_W+1)'(dec_pop) > count_q) ? count_q[1:0] : dec_pop;

  // Normal entries carry no cause; the code is only meaningful with is_exc.
  assign wr_entry1 = pack_entry(in_pc1, in_inst1, in_pred_addr, in_is_exception,
                                in_is_exception ? in_exception_cause : '0);
  assign wr_entry2 = pack_entry(in_pc2, in_inst2, in_pred_addr, 1'b0, '0);

  // NOTE: every always_comb output is given a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = wr_entry1;
        if (!in_is_exception) mem_d[tail_q + PTR_W'(1)] = wr_entry2;
        tail_d = tail_q + PTR_W'(push_n);
      end
      head_d  = head_q + PTR_W'(eff_pop);
      count_d = count_q + (push_ok ? (PTR_W+1)'(push_n) : '0)
                        - (PTR_W+1)'(eff_pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; stale entries are
  // never visible because the outputs are gated by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid1 = count_q >= (PTR_W+1)'(1);
  assign out_valid2 = count_q >= (PTR_W+1)'(2);
  assign slot1      = out_valid1 ? mem_q[head_q]              : '0;
  assign slot2      = out_valid2 ? mem_q[head_q + PTR_W'(1)]  : '0;

  assign out_pc1              = slot1[PC_OFF    +: 32];
  assign out_inst1            = slot1[INST_OFF  +: 32];
  assign out_pred_addr1       = slot1[PRED_OFF  +: 32];
  assign out_is_exception1    = slot1[EXC_OFF];
  assign out_exception_cause1 = slot1[CAUSE_OFF +: EXC_CAUSE_W];
  assign out_pc2              = slot2[PC_OFF    +: 32];
  assign out_inst2            = slot2[INST_OFF  +: 32];
  assign out_pred_addr2       = slot2[PRED_OFF  +: 32];
  assign out_is_exception2    = slot2[EXC_OFF];
  assign out_exception_cause2 = slot2[CAUSE_OFF +: EXC_CAUSE_W];

  // Fetch is required to hold while buf_full; a pair offered anyway is lost.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (rst) !(in_valid && buf_full && !flush));

`ifdef INST_BUF_PERF_EN
  inst_buf_perf u_perf (
    .clk              (clk),
    .rst              (rst),
    .full_evt         (buf_full & in_valid),
    .flush_evt        (flush),
    .perf_full_cycles (perf_full_cycles),
    .perf_flush_cnt   (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer
//   Directed scenarios followed by random traffic for inst_buffer. Expected
//   outputs come from a queue-based reference model of the buffer contents.
// -----------------------------------------------------------------------------
module tb_inst_buffer;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pred;
    logic        exc;
    logic [6:0]  cause;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst1, in_inst2, in_pc1, in_pc2, in_pred_addr;
  logic        in_is_exception;
  logic [6:0]  in_exception_cause;
  logic        buf_full;
  logic        out_valid1, out_valid2;
  logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2;
  logic [31:0] out_pred_addr1, out_pred_addr2;
  logic        out_is_exception1, out_is_exception2;
  logic [6:0]  out_exception_cause1, out_exception_cause2;
  logic [1:0]  dec_pop;
`ifdef INST_BUF_PERF_EN
  logic [31:0] perf_full_cycles, perf_flush_cnt;
  logic [31:0] flush_cnt_before;
`endif

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  inst_buffer #(.DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_inst1             (in_inst1),
    .in_inst2             (in_inst2),
    .in_pc1               (in_pc1),
    .in_pc2               (in_pc2),
    .in_pred_addr         (in_pred_addr),
    .in_is_exception      (in_is_exception),
    .in_exception_cause   (in_exception_cause),
    .buf_full             (buf_full),
    .out_valid1           (out_valid1),
    .out_valid2           (out_valid2),
    .out_inst1            (out_inst1),
    .out_inst2            (out_inst2),
    .out_pc1              (out_pc1),
    .out_pc2              (out_pc2),
    .out_pred_addr1       (out_pred_addr1),
    .out_pred_addr2       (out_pred_addr2),
    .out_is_exception1    (out_is_exception1),
    .out_is_exception2    (out_is_exception2),
    .out_exception_cause1 (out_exception_cause1),
    .out_exception_cause2 (out_exception_cause2),
    .dec_pop              (dec_pop)
`ifdef INST_BUF_PERF_EN
    ,
    .perf_full_cycles     (perf_full_cycles),
    .perf_flush_cnt       (perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the two oldest model entries.
  task automatic check_outputs(input string tag);
    ent_t e1, e2;
    e1 = '{pc: '0, inst: '0, pred: '0, exc: 1'b0, cause: '0};
    e2 = e1;
    if (q.size() >= 1) e1 = q[0];
    if (q.size() >= 2) e2 = q[1];
    check({tag, ".full"},   32'(buf_full),   32'((DEPTH - q.size()) < 2));
    check({tag, ".valid1"}, 32'(out_valid1), 32'(q.size() >= 1));
    check({tag, ".valid2"}, 32'(out_valid2), 32'(q.size() >= 2));
    check({tag, ".pc1"},    out_pc1,         e1.pc);
    check({tag, ".inst1"},  out_inst1,       e1.inst);
    check({tag, ".pred1"},  out_pred_addr1,  e1.pred);
    check({tag, ".exc1"},   32'(out_is_exception1),    32'(e1.exc));
    check({tag, ".cause1"}, 32'(out_exception_cause1), 32'(e1.cause));
    check({tag, ".pc2"},    out_pc2,         e2.pc);
    check({tag, ".inst2"},  out_inst2,       e2.inst);
    check({tag, ".pred2"},  out_pred_addr2,  e2.pred);
    check({tag, ".exc2"},   32'(out_is_exception2),    32'(e2.exc));
    check({tag, ".cause2"}, 32'(out_exception_cause2), 32'(e2.cause));
  endtask

  // Reference model: one clock edge applied to the queue of stored entries.
  function automatic void model_clock();
    bit full;
    int n;
    if (flush) begin
      q.delete();
      return;
    end
    full = (DEPTH - q.size()) < 2;
    n    = (int'(dec_pop) > q.size()) ? q.size() : int'(dec_pop);
    repeat (n) void'(q.pop_front());
    if (in_valid && !full) begin
      if (in_is_exception) begin
        q.push_back('{pc: in_pc1, inst: in_inst1, pred: in_pred_addr,
                      exc: 1'b1, cause: in_exception_cause});
      end else begin
        q.push_back('{pc: in_pc1, inst: in_inst1, pred: in_pred_addr, exc: 1'b0, cause: '0});
        q.push_back('{pc: in_pc2, inst: in_inst2, pred: in_pred_addr, exc: 1'b0, cause: '0});
      end
    end
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc1, input logic [31:0] pc2,
                       input logic exc, input logic [6:0] cause,
                       input logic [1:0] pop, input logic fl);
    in_valid           = v;
    in_pc1             = pc1;
    in_pc2             = pc2;
    in_inst1           = $urandom;
    in_inst2           = $urandom;
    in_pred_addr       = $urandom;
    in_is_exception    = exc;
    in_exception_cause = exc ? cause : 7'h0;
    dec_pop            = pop;
    flush              = fl;
  endtask

  task automatic drive_rand(input logic v, input logic exc, input logic [1:0] pop,
                            input logic fl);
    logic [31:0] pc;
    pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    drive(v, pc, pc + 32'd4, exc, 7'($urandom_range(0, 127)), pop, fl);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, '0, '0, 1'b0, '0, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    q.delete();
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit v, exc, fl;

    // 1. Reset and idle.
    rst = 1'b0;
    do_reset("reset");
    step("idle0");
    step("idle1");

    // 2. One pair, visible the following cycle.
    drive(1'b1, 32'h1c00_0000, 32'h1c00_0004, 1'b0, '0, 2'd0, 1'b0);
    step("t2.push");
    check("t2.pc1_const", out_pc1, 32'h1c00_0000);
    check("t2.pc2_const", out_pc2, 32'h1c00_0004);
    drive(1'b0, '0, '0, 1'b0, '0, 2'd2, 1'b0);
    step("t2.pop");

    // 3. Fill with 8 pairs, free 2 slots, accept a 9th, then drain.
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1, 1'b0, 2'd0, 1'b0);
      step("t3.fill");
    end
    check("t3.full_after_8", 32'(buf_full), 32'd1);
    drive(1'b0, '0, '0, 1'b0, '0, 2'd2, 1'b0);
    step("t3.pop2");
    check("t3.not_full", 32'(buf_full), 32'd0);
    drive_rand(1'b1, 1'b0, 2'd0, 1'b0);
    step("t3.ninth");
    check("t3.full_again", 32'(buf_full), 32'd1);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, '0, '0, 1'b0, '0, 2'd2, 1'b0);
      step("t3.drain");
    end

    // 4. Move head and tail to slot 15, then push a straddling pair.
    do_reset("t4.reset");
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1, i == 7, 2'd2, 1'b0);
      step("t4.advance");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0, '0, 2'd2, 1'b0);
      step("t4.empty");
    end
    drive(1'b1, 32'h0000_a000, 32'h0000_a004, 1'b0, '0, 2'd0, 1'b0);
    step("t4.wrap_push");
    check("t4.a0_first",  out_pc1, 32'h0000_a000);
    check("t4.a1_second", out_pc2, 32'h0000_a004);
    drive(1'b0, '0, '0, 1'b0, '0, 2'd1, 1'b0);
    step("t4.pop_a0");
    check("t4.a1_at_head", out_pc1, 32'h0000_a004);
    step("t4.pop_a1");

    // 5. Exception pair keeps only its first instruction.
    drive(1'b1, 32'h0000_2000, 32'h0000_2004, 1'b1, 7'h08, 2'd0, 1'b0);
    step("t5.exc_push");
    check("t5.exc1",   32'(out_is_exception1),    32'd1);
    check("t5.cause1", 32'(out_exception_cause1), 32'h08);
    check("t5.valid2", 32'(out_valid2),           32'd0);
    drive(1'b0, '0, '0, 1'b0, '0, 2'd1, 1'b0);
    step("t5.pop");

    // 6. Flush beats a simultaneous push and pop.
    drive_rand(1'b1, 1'b0, 2'd0, 1'b0); step("t6.fill");
    drive_rand(1'b1, 1'b0, 2'd0, 1'b0); step("t6.fill");
    drive_rand(1'b1, 1'b1, 2'd0, 1'b0); step("t6.fill");
    check("t6.count5_valid2", 32'(out_valid2), 32'd1);
`ifdef INST_BUF_PERF_EN
    flush_cnt_before = perf_flush_cnt;
`endif
    drive_rand(1'b1, 1'b0, 2'd2, 1'b1);
    step("t6.flush");
    check("t6.valid1", 32'(out_valid1), 32'd0);
    check("t6.full",   32'(buf_full),   32'd0);
`ifdef INST_BUF_PERF_EN
    check("t6.perf_flush", perf_flush_cnt, flush_cnt_before + 32'd1);
`endif

    // Random traffic; fetch honours the model's full flag.
    for (int i = 0; i < 400; i++) begin
      fl  = ($urandom_range(0, 24) == 0);
      exc = ($urandom_range(0, 5) == 0);
      v   = ((DEPTH - q.size()) >= 2) && ($urandom_range(0, 3) != 0);
      drive_rand(v, exc, 2'($urandom_range(0, 2)), fl);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
